mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: ADDR_W, default 11, SRAM word-address width; the word address is aluResult_mem[ADDR_W+1:2].
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 aluResult_ex / writeDataToSRAM_ex / branchTrue_ex  in  32 each  EX-stage results: address or ALU value, store data, branch target.
REQ-005 writeRegOut_ex  in  5  EX destination register; zero_ex  in  1  ALU zero flag.
REQ-006 MemRead_ex, MemWrite_ex, RegWrite_ex, MemToReg_ex, Branch_ex  in  1 each  control bits travelling with the instruction.
REQ-007 aluResult_mem  out  32; writeReg_mem  out  5; RegWrite_mem  out  1  EX/MEM register contents, exported for forwarding.
REQ-008 PCSrc  out  1; branchTarget_mem  out  32  branch-taken flag and target.
REQ-009 stall_mem  out  1  freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-010 sram_req, sram_we  out  1; sram_addr  out  ADDR_W; sram_wdata  out  32; sram_rdata  in  32; sram_ack  in  1  data-memory handshake.
REQ-011 writeDataToReg_wb  out  32; writeReg_wb  out  5; RegWrite_wb  out  1  MEM/WB register outputs.
REQ-012 addr_err  out  1  misaligned access flag (see Configuration).

Function
REQ-013 EX/MEM register SHALL load all *_ex inputs on each edge where stall_mem=0 and SHALL hold while stall_mem=1.
REQ-014 memop = MemRead_mem | MemWrite_mem, where both are EX/MEM register bits.
REQ-015 FSM SHALL have two states: IDLE and REQ.
  - IDLE to REQ on an edge where memop=1 and no misaligned-suppression applies.
  - REQ to IDLE on an edge where sram_ack=1.
REQ-016 sram_req SHALL be 1 exactly when state=REQ.
  - sram_we = MemWrite_mem.
  - sram_addr and sram_wdata SHALL be driven from EX/MEM and held stable while sram_req=1.
REQ-017 stall_mem SHALL be memop & ~(state==REQ & sram_ack), suppressed when addr_err=1.
  - A memory op stalls for at least 1 cycle; minimum MEM occupancy is 2 cycles.
  - Ack cycle: stall_mem=0 combinationally.
REQ-018 MEM/WB loads on every edge.
  - While stall_mem=1, RegWrite_wb SHALL load 0 (bubble).
  - Otherwise writeDataToReg_wb = MemToReg_mem ? sram_rdata : aluResult_mem.
  - Otherwise writeReg_wb = writeReg_mem and RegWrite_wb = RegWrite_mem.
REQ-019 A non-memory instruction SHALL reach MEM/WB exactly 1 cycle after entering EX/MEM.
  - A load SHALL reach MEM/WB on the sram_ack edge.
REQ-020 PCSrc SHALL be Branch_mem & zero_mem (combinational from EX/MEM); branchTarget_mem = branchTrue_mem.
REQ-021 Back-to-back memory ops: the second op latches on the first op's ack edge and enters REQ on the following edge.
REQ-022 sram_ack received in IDLE SHALL be ignored.

Reset
REQ-023 reset_n=0 SHALL immediately, regardless of clk:
  - force state=IDLE;
  - clear every EX/MEM and MEM/WB bit to 0.
  - As a result, sram_req, stall_mem, PCSrc, RegWrite_mem, RegWrite_wb and addr_err are 0 and all data outputs are 0.
REQ-024 Reset asserted during REQ SHALL abandon the access; no MEM/WB update for it after release.

Configuration
REQ-025 Macro MEM_ALIGN_CHECK_EN.
  - Defined: memop with aluResult_mem[1:0]!=0 SHALL set addr_err=1 for that instruction's MEM cycle, SHALL NOT enter REQ or stall, and SHALL write a bubble to MEM/WB.
  - Undefined: addr_err tied to 0; low address bits are ignored.

Verification
REQ-026 ADD, aluResult_ex=0x0000_0010, writeRegOut_ex=5, RegWrite_ex=1 -> next cycle aluResult_mem=0x10; following cycle writeDataToReg_wb=0x10, writeReg_wb=5, RegWrite_wb=1, stall_mem never 1.
REQ-027 LW, address 0x40, sram_ack 3 cycles after sram_req rises, sram_rdata=0xDEADBEEF -> sram_addr=0x10, stall_mem high 3 cycles, RegWrite_wb=0 during stall, then writeDataToReg_wb=0xDEADBEEF.
REQ-028 SW, address 0x8, writeDataToSRAM_ex=0x1234 -> sram_we=1, sram_wdata=0x1234, sram_addr=2 held until ack; RegWrite_wb=0.
REQ-029 Branch_ex=1, zero_ex=1, branchTrue_ex=0x100 -> PCSrc=1, branchTarget_mem=0x100 for one cycle; with zero_ex=0 -> PCSrc=0.
REQ-030 LW then LW back-to-back, reset_n pulsed low mid-REQ of the second -> sram_req and stall_mem drop at once; no MEM/WB write after release.
REQ-031 MEM_ALIGN_CHECK_EN defined, LW address 0x42 -> addr_err=1 one cycle, sram_req stays 0, RegWrite_wb=0.

Source files
------------

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory SRAM handshake bundle for the MEM stage
interface mem_stage_if #(
  parameter int ADDR_W = 11
);
  logic              sram_req;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;
  logic              sram_ack;

  // Pipeline side issues requests.
  modport master (
    output sram_req, sram_we, sram_addr, sram_wdata,
    input  sram_rdata, sram_ack
  );

  // Memory side answers them.
  modport slave (
    input  sram_req, sram_we, sram_addr, sram_wdata,
    output sram_rdata, sram_ack
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - EX/MEM register, SRAM access FSM and MEM/WB register (option: MEM_ALIGN_CHECK_EN)
module mem_stage #(
  parameter int ADDR_W = 11
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] aluResult_ex,
  input  logic [31:0] writeDataToSRAM_ex,
  input  logic [31:0] branchTrue_ex,
  input  logic [4:0]  writeRegOut_ex,
  input  logic        zero_ex,
  input  logic        MemRead_ex,
  input  logic        MemWrite_ex,
  input  logic        RegWrite_ex,
  input  logic        MemToReg_ex,
  input  logic        Branch_ex,
  output logic [31:0] aluResult_mem,
  output logic [4:0]  writeReg_mem,
  output logic        RegWrite_mem,
  output logic        PCSrc,
  output logic [31:0] branchTarget_mem,
  output logic        stall_mem,
  mem_stage_if.master sram,
  output logic [31:0] writeDataToReg_wb,
  output logic [4:0]  writeReg_wb,
  output logic        RegWrite_wb,
  output logic        addr_err
);

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  state_t      r_state;
  logic [31:0] r_alu;
  logic [31:0] r_wdata;
  logic [31:0] r_btgt;
  logic [4:0]  r_wreg;
  logic        r_zero;
  logic        r_mem_read;
  logic        r_mem_write;
  logic        r_reg_write;
  logic        r_mem_to_reg;
  logic        r_branch;
  logic [31:0] r_wb_data;
  logic [4:0]  r_wb_reg;
  logic        r_wb_regwrite;

  logic        w_memop;
  logic        w_addr_err;
  logic        w_ack_now;
  logic        w_stall;

  assign w_memop = r_mem_read | r_mem_write;

`ifdef MEM_ALIGN_CHECK_EN
  // A misaligned access is dropped in its single MEM cycle instead of going to SRAM.
  assign w_addr_err = w_memop & (r_alu[1:0] != 2'b00);
`else
  assign w_addr_err = 1'b0;
`endif

  // The ack cycle releases the stall combinationally so the next op can latch on that edge.
  assign w_ack_now = (r_state == S_REQ) & sram.sram_ack;
  assign w_stall   = w_memop & ~w_ack_now & ~w_addr_err;

  // EX/MEM register: frozen while the memory access is outstanding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alu        <= '0;
      r_wdata      <= '0;
      r_btgt       <= '0;
      r_wreg       <= '0;
      r_zero       <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_branch     <= 1'b0;
    end else if (!w_stall) begin
      r_alu        <= aluResult_ex;
      r_wdata      <= writeDataToSRAM_ex;
      r_btgt       <= branchTrue_ex;
      r_wreg       <= writeRegOut_ex;
      r_zero       <= zero_ex;
      r_mem_read   <= MemRead_ex;
      r_mem_write  <= MemWrite_ex;
      r_reg_write  <= RegWrite_ex;
      r_mem_to_reg <= MemToReg_ex;
      r_branch     <= Branch_ex;
    end
  end

  // Access FSM: one IDLE cycle to see the op, then hold REQ until the SRAM acks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_memop && !w_addr_err) r_state <= S_REQ;
        S_REQ:   if (sram.sram_ack)          r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // MEM/WB register: loads every cycle, bubbles while stalled or on a dropped access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wb_data     <= '0;
      r_wb_reg      <= '0;
      r_wb_regwrite <= 1'b0;
    end else begin
      r_wb_data     <= r_mem_to_reg ? sram.sram_rdata : r_alu;
      r_wb_reg      <= r_wreg;
      r_wb_regwrite <= r_reg_write & ~w_stall & ~w_addr_err;
    end
  end

  assign aluResult_mem     = r_alu;
  assign writeReg_mem      = r_wreg;
  assign RegWrite_mem      = r_reg_write;
  assign PCSrc             = r_branch & r_zero;
  assign branchTarget_mem  = r_btgt;
  assign stall_mem         = w_stall;
  assign addr_err          = w_addr_err;

  assign sram.sram_req     = (r_state == S_REQ);
  assign sram.sram_we      = r_mem_write;
  assign sram.sram_addr    = r_alu[ADDR_W+1:2];
  assign sram.sram_wdata   = r_wdata;

  assign writeDataToReg_wb = r_wb_data;
  assign writeReg_wb       = r_wb_reg;
  assign RegWrite_wb       = r_wb_regwrite;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage
module tb_mem_stage;

  localparam int ADDR_W = 11;

  logic        clk;
  logic        reset_n;
  logic [31:0] aluResult_ex, writeDataToSRAM_ex, branchTrue_ex;
  logic [4:0]  writeRegOut_ex;
  logic        zero_ex, MemRead_ex, MemWrite_ex, RegWrite_ex, MemToReg_ex, Branch_ex;
  logic [31:0] aluResult_mem, branchTarget_mem, writeDataToReg_wb;
  logic [4:0]  writeReg_mem, writeReg_wb;
  logic        RegWrite_mem, PCSrc, stall_mem, RegWrite_wb, addr_err;

  mem_stage_if #(.ADDR_W(ADDR_W)) sram_if ();

  mem_stage #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .aluResult_ex(aluResult_ex), .writeDataToSRAM_ex(writeDataToSRAM_ex),
    .branchTrue_ex(branchTrue_ex), .writeRegOut_ex(writeRegOut_ex), .zero_ex(zero_ex),
    .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex), .RegWrite_ex(RegWrite_ex),
    .MemToReg_ex(MemToReg_ex), .Branch_ex(Branch_ex),
    .aluResult_mem(aluResult_mem), .writeReg_mem(writeReg_mem), .RegWrite_mem(RegWrite_mem),
    .PCSrc(PCSrc), .branchTarget_mem(branchTarget_mem), .stall_mem(stall_mem),
    .sram(sram_if.master),
    .writeDataToReg_wb(writeDataToReg_wb), .writeReg_wb(writeReg_wb),
    .RegWrite_wb(RegWrite_wb), .addr_err(addr_err)
  );

  typedef struct {
    logic [31:0] d;
    logic [4:0]  r;
  } wb_t;

  wb_t         sb[$];
  logic [31:0] mem     [2**ADDR_W];
  logic [31:0] ref_mem [2**ADDR_W];
  int          checks = 0;
  int          errors = 0;
  int          lat = 1;
  int          req_cnt = 0;
  logic        spurious = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // SRAM model: acks on the lat-th cycle of a request, optional stray ack while idle.
  always begin
    @(posedge clk);
    #1;
    if (sram_if.sram_req === 1'b1) begin
      req_cnt++;
      sram_if.sram_ack = (req_cnt == lat);
    end else begin
      req_cnt = 0;
      sram_if.sram_ack = spurious;
    end
    if (sram_if.sram_ack && sram_if.sram_req === 1'b1) begin
      sram_if.sram_rdata = mem[sram_if.sram_addr];
      if (sram_if.sram_we) mem[sram_if.sram_addr] = sram_if.sram_wdata;
    end else begin
      sram_if.sram_rdata = $urandom;
    end
  end

  // Writeback monitor: every register write must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && RegWrite_wb === 1'b1) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", 32'd1, 32'd0);
      end else begin
        wb_t e;
        e = sb.pop_front();
        check("wb_data", writeDataToReg_wb, e.d);
        check("wb_reg", {27'd0, writeReg_wb}, {27'd0, e.r});
      end
    end
  end

  task automatic drive_nop();
    aluResult_ex = '0; writeDataToSRAM_ex = '0; branchTrue_ex = '0; writeRegOut_ex = '0;
    zero_ex = 0; MemRead_ex = 0; MemWrite_ex = 0; RegWrite_ex = 0; MemToReg_ex = 0; Branch_ex = 0;
  endtask

  // Presents one instruction (caller is at a negedge with stall_mem low), returns at the
  // negedge of its last MEM cycle with the number of stalled cycles observed.
  task automatic exec(input string tag, input logic [31:0] alu, input logic [31:0] wd,
                      input logic [31:0] bt, input logic [4:0] wr, input logic mr,
                      input logic mw, input logic rw, input logic m2r, input logic br,
                      input logic zr, input int lat_i, output int stalls);
    logic mis;
    int   guard;
    wb_t  e;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (mr | mw) && (alu[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    lat = lat_i;
    if (rw && !mis) begin
      e.d = m2r ? ref_mem[alu[ADDR_W+1:2]] : alu;
      e.r = wr;
      sb.push_back(e);
    end
    if (mw && !mis) ref_mem[alu[ADDR_W+1:2]] = wd;
    aluResult_ex = alu; writeDataToSRAM_ex = wd; branchTrue_ex = bt; writeRegOut_ex = wr;
    zero_ex = zr; MemRead_ex = mr; MemWrite_ex = mw; RegWrite_ex = rw; MemToReg_ex = m2r;
    Branch_ex = br;
    @(posedge clk);
    #1 drive_nop();
    stalls = 0;
    guard  = 0;
    @(negedge clk);
    while (stall_mem === 1'b1 && guard < 40) begin
      stalls++;
      if (stalls > 1) check($sformatf("%s_bubble", tag), RegWrite_wb, 0);
      if (sram_if.sram_req === 1'b1) begin
        check($sformatf("%s_addr", tag), sram_if.sram_addr, alu[ADDR_W+1:2]);
        check($sformatf("%s_we", tag), sram_if.sram_we, mw);
        if (mw) check($sformatf("%s_wdata", tag), sram_if.sram_wdata, wd);
      end
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) check($sformatf("%s_timeout", tag), 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    logic exp_mis;
    for (int i = 0; i < 2**ADDR_W; i++) begin
      mem[i]     = 32'hA5000000 ^ i;
      ref_mem[i] = 32'hA5000000 ^ i;
    end
    mem[16'h10]     = 32'hDEADBEEF;
    ref_mem[16'h10] = 32'hDEADBEEF;
    sram_if.sram_ack   = 1'b0;
    sram_if.sram_rdata = '0;
    drive_nop();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check("rst_req", sram_if.sram_req, 0);
    check("rst_stall", stall_mem, 0);
    check("rst_pcsrc", PCSrc, 0);
    check("rst_regwrite_mem", RegWrite_mem, 0);
    check("rst_regwrite_wb", RegWrite_wb, 0);
    check("rst_addr_err", addr_err, 0);
    check("rst_alu_mem", aluResult_mem, 0);
    check("rst_wb_data", writeDataToReg_wb, 0);
    check("rst_btgt", branchTarget_mem, 0);
    check("rst_sram_wdata", sram_if.sram_wdata, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // ADD: one cycle in MEM, written back the cycle after.
    exec("add", 32'h10, 0, 0, 5'd5, 0, 0, 1, 0, 0, 0, 1, st);
    check("add_stalls", st, 0);
    check("add_alu_mem", aluResult_mem, 32'h10);
    check("add_regwrite_mem", RegWrite_mem, 1);
    @(negedge clk);
    check("add_wb_valid", RegWrite_wb, 1);
    check("add_wb_data", writeDataToReg_wb, 32'h10);
    check("add_wb_reg", writeReg_wb, 5);

    // LW 0x40 with ack on the third request cycle.
    exec("lw", 32'h40, 0, 0, 5'd7, 1, 0, 1, 1, 0, 0, 3, st);
    check("lw_stalls", st, 3);
    check("lw_ack_addr", sram_if.sram_addr, 32'h10);
    @(negedge clk);
    check("lw_wb_valid", RegWrite_wb, 1);
    check("lw_wb_data", writeDataToReg_wb, 32'hDEADBEEF);

    // SW 0x8, then read it back with minimum latency.
    exec("sw", 32'h8, 32'h1234, 0, 5'd0, 0, 1, 0, 0, 0, 0, 2, st);
    check("sw_stalls", st, 2);
    check("sw_mem", mem[2], 32'h1234);
    exec("lw2", 32'h8, 0, 0, 5'd9, 1, 0, 1, 1, 0, 0, 1, st);
    check("lw2_stalls", st, 1);

    // Several random ALU ops and memory ops with varied latency.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      a = {19'd0, $urandom_range(0, 2**ADDR_W - 1), 2'b00};
      case (i % 3)
        0: exec("rnd_alu", $urandom, 0, 0, 5'($urandom_range(1, 31)), 0, 0, 1, 0, 0, 0, 1, st);
        1: exec("rnd_sw", a, $urandom, 0, 0, 0, 1, 0, 0, 0, 0, 1 + i % 4, st);
        default: exec("rnd_lw", a, 0, 0, 5'($urandom_range(1, 31)), 1, 0, 1, 1, 0, 0, 1 + i % 4, st);
      endcase
    end

    // Branch taken and not taken.
    exec("br_t", 32'h0, 0, 32'h100, 0, 0, 0, 0, 0, 1, 1, 1, st);
    check("br_t_pcsrc", PCSrc, 1);
    check("br_t_target", branchTarget_mem, 32'h100);
    @(negedge clk);
    check("br_t_pcsrc_drop", PCSrc, 0);
    exec("br_n", 32'h4, 0, 32'h100, 0, 0, 0, 0, 0, 1, 0, 1, st);
    check("br_n_pcsrc", PCSrc, 0);

    // Stray ack while idle must not start or finish anything.
    @(negedge clk);
    spurious = 1'b1;
    @(negedge clk);
    check("spur_req", sram_if.sram_req, 0);
    check("spur_stall", stall_mem, 0);
    spurious = 1'b0;
    @(negedge clk);
    check("spur_wb", RegWrite_wb, 0);

    // Misaligned load.
`ifdef MEM_ALIGN_CHECK_EN
    exp_mis = 1'b1;
`else
    exp_mis = 1'b0;
`endif
    exec("mis", 32'h42, 0, 0, 5'd3, 1, 0, 1, 1, 0, 0, 1, st);
    check("mis_addr_err", addr_err, exp_mis);
    check("mis_stalls", st, exp_mis ? 0 : 1);
    if (exp_mis) check("mis_req", sram_if.sram_req, 0);
    @(negedge clk);
    check("mis_addr_err_clear", addr_err, 0);
    if (exp_mis) check("mis_wb", RegWrite_wb, 0);

    // Back-to-back loads, reset pulsed while the second is in REQ.
    exec("b2b1", 32'h40, 0, 0, 5'd11, 1, 0, 1, 1, 0, 0, 1, st);
    lat = 10;
    aluResult_ex = 32'h44; writeRegOut_ex = 5'd12; MemRead_ex = 1; RegWrite_ex = 1; MemToReg_ex = 1;
    @(posedge clk);
    #1 drive_nop();
    @(negedge clk);
    check("b2b_idle_req", sram_if.sram_req, 0);
    check("b2b_idle_stall", stall_mem, 1);
    @(negedge clk);
    check("b2b_req", sram_if.sram_req, 1);
    #2 reset_n = 1'b0;
    #1;
    check("b2b_rst_req", sram_if.sram_req, 0);
    check("b2b_rst_stall", stall_mem, 0);
    check("b2b_rst_wb", RegWrite_wb, 0);
    @(negedge clk);
    reset_n = 1'b1;
    lat = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_post_wb", RegWrite_wb, 0);
      check("b2b_post_req", sram_if.sram_req, 0);
    end

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
